// File: rtl/vga_pattern_engine_if.sv
// Video output bundle of the pattern engine: syncs, display enable, coordinates and colour.
interface vga_pattern_engine_if #(
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 10,
  parameter int unsigned COLOR_W = 4
);
  logic               h_sync;
  logic               v_sync;
  logic               DE;
  logic [X_W-1:0]     pixel_x;
  logic [Y_W-1:0]     pixel_y;
  logic [COLOR_W-1:0] r_port;
  logic [COLOR_W-1:0] g_port;
  logic [COLOR_W-1:0] b_port;
  logic               frame_start;

  modport master (
    output h_sync, v_sync, DE, pixel_x, pixel_y, r_port, g_port, b_port, frame_start
  );

  modport slave (
    input  h_sync, v_sync, DE, pixel_x, pixel_y, r_port, g_port, b_port, frame_start
  );
endinterface

// File: rtl/vga_pattern_engine.sv
// VGA timing generator with four test patterns; every output comes straight from a flop
// and lags the raster counters by exactly one pixel enable.
module vga_pattern_engine #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned SYNC_POL   = 0,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] r_sw,
  input  logic [COLOR_W-1:0] g_sw,
  input  logic [COLOR_W-1:0] b_sw,
  vga_pattern_engine_if.master vid
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned X_W      = $clog2(H_TOTAL);
  localparam int unsigned Y_W      = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
  localparam logic        SYNC_IDLE = (SYNC_POL == 0);

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;

  logic [X_W-1:0]     h_cnt;
  logic [Y_W-1:0]     v_cnt;
  logic [7:0]         frame_cnt;
  logic [1:0]         mode_q;

  logic               at_origin;
  logic [1:0]         mode_sel;
  logic [31:0]        h32;
  logic [31:0]        v32;
  logic               raw_de;
  logic               raw_hs;
  logic               raw_vs;
  logic [2:0]         bar_k;
  logic [X_W-1:0]     grad_x;
  logic [COLOR_W-1:0] r_nxt;
  logic [COLOR_W-1:0] g_nxt;
  logic [COLOR_W-1:0] b_nxt;

  // Raster decode and pattern generation for the pixel the counters point at now.
  always_comb begin
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    mode_sel  = at_origin ? mode : mode_q;
    h32       = 32'(h_cnt);
    v32       = 32'(v_cnt);
    raw_de    = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    raw_hs    = (h32 >= HS_START) && (h32 < HS_START + H_SYNC);
    raw_vs    = (v32 >= VS_START) && (v32 < VS_START + V_SYNC);
    grad_x    = h_cnt + X_W'(frame_cnt);
    bar_k     = 3'd0;
    r_nxt     = '0;
    g_nxt     = '0;
    b_nxt     = '0;

    // Bar index by threshold count avoids a divider for non power-of-two bar widths.
    for (int unsigned i = 1; i < 8; i++) begin
      if (h32 >= i * BAR_W) bar_k = bar_k + 3'd1;
    end

    case (mode_sel)
      MODE_SOLID: begin
        r_nxt = r_sw;
        g_nxt = g_sw;
        b_nxt = b_sw;
      end
      MODE_BARS: begin
        r_nxt = bar_k[1] ? '0 : '1;
        g_nxt = bar_k[2] ? '0 : '1;
        b_nxt = bar_k[0] ? '0 : '1;
      end
      MODE_CHECK: begin
        if ((((h32 >> CHECK_LOG2) ^ (v32 >> CHECK_LOG2)) & 32'd1) == 32'd0) begin
          r_nxt = r_sw;
          g_nxt = g_sw;
          b_nxt = b_sw;
        end
      end
      default: begin
        r_nxt = COLOR_W'(32'(grad_x) >> 4);
        g_nxt = COLOR_W'(v32 >> 4);
        b_nxt = b_sw;
      end
    endcase

    if (!raw_de) begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
    end
  end

  // Counters, frame bookkeeping and the registered video outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      frame_cnt       <= '0;
      mode_q          <= '0;
      vid.h_sync      <= SYNC_IDLE;
      vid.v_sync      <= SYNC_IDLE;
      vid.DE          <= 1'b0;
      vid.pixel_x     <= '0;
      vid.pixel_y     <= '0;
      vid.r_port      <= '0;
      vid.g_port      <= '0;
      vid.b_port      <= '0;
      vid.frame_start <= 1'b0;
    end else begin
      // Pulse lasts one clk even when pix_en is a sparse strobe.
      vid.frame_start <= pix_en && at_origin;
      if (pix_en) begin
        if (h_cnt == X_W'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == Y_W'(V_TOTAL - 1)) ? '0 : v_cnt + Y_W'(1);
        end else begin
          h_cnt <= h_cnt + X_W'(1);
        end
        if (at_origin) begin
          mode_q    <= mode;
          frame_cnt <= frame_cnt + 8'd1;
        end
        vid.h_sync  <= raw_hs ^ SYNC_IDLE;
        vid.v_sync  <= raw_vs ^ SYNC_IDLE;
        vid.DE      <= raw_de;
        vid.pixel_x <= h_cnt;
        vid.pixel_y <= v_cnt;
        vid.r_port  <= r_nxt;
        vid.g_port  <= g_nxt;
        vid.b_port  <= b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Directed bench: a default-timing instance for pixel-exact pattern checks and a tiny-timing
// instance (active-high syncs) for whole-frame, enable-gating and reset sequences.
module tb_vga_pattern_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, pe_a = 1'b0;
  logic       rst_b = 1'b0, pe_b = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
  logic [3:0] r_sw = 4'hA, g_sw = 4'h5, b_sw = 4'h3;

  vga_pattern_engine_if #(.X_W(10), .Y_W(10), .COLOR_W(4)) vid_a ();
  vga_pattern_engine_if #(.X_W(5),  .Y_W(5),  .COLOR_W(4)) vid_b ();

  vga_pattern_engine dut_a (
    .clk(clk), .reset(rst_a), .pix_en(pe_a), .mode(mode_a),
    .r_sw(r_sw), .g_sw(g_sw), .b_sw(b_sw), .vid(vid_a)
  );

  // 24 x 18 total raster, 16 x 12 visible, 2-px bars, 4-px checker squares.
  vga_pattern_engine #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .COLOR_W(4), .SYNC_POL(1), .CHECK_LOG2(2)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_en(pe_b), .mode(mode_b),
    .r_sw(r_sw), .g_sw(g_sw), .b_sw(b_sw), .vid(vid_b)
  );

  typedef struct {
    int mode; int x; int y; int de; int hs; int r; int g; int b;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fs_b  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b();
    tick();
    if (vid_b.frame_start) fs_b++;
  endtask

  task automatic seek_a(input int x, input int y);
    int n = 0;
    while (!(int'(vid_a.pixel_x) == x && int'(vid_a.pixel_y) == y) && n < 60000) begin
      tick();
      n++;
    end
    check($sformatf("seek_a(%0d,%0d)", x, y), int'(n < 60000), 1);
  endtask

  task automatic seek_b(input int x, input int y);
    int n = 0;
    while (!(int'(vid_b.pixel_x) == x && int'(vid_b.pixel_y) == y) && n < 1000) begin
      tick_b();
      n++;
    end
    check($sformatf("seek_b(%0d,%0d)", x, y), int'(n < 1000), 1);
  endtask

  task automatic wait_fs_b(input string name, input int bound, output int clks);
    clks = 0;
    do begin
      tick_b();
      clks++;
    end while (!vid_b.frame_start && clks < bound);
    check(name, int'(vid_b.frame_start), 1);
  endtask

  task automatic restart_a(input logic [1:0] m);
    rst_a = 1'b0;
    pe_a  = 1'b1;
    tick();
    tick();
    rst_a  = 1'b1;
    mode_a = m;
    tick();
    check($sformatf("a_fs_after_release_m%0d", m), int'(vid_a.frame_start), 1);
  endtask

  function automatic void add(input int m, input int x, input int y, input int de,
                              input int hs, input int r, input int g, input int b);
    vecs.push_back('{m, x, y, de, hs, r, g, b});
  endfunction

  initial begin
    int  cur_mode;
    int  clks, hs_n, vs_n, de_n, bad, hold_bad;
    logic [24:0] snap;
    logic        pe_used;

    // mode, x, y, DE, h_sync (active low), R, G, B
    add(1,   0,  0, 1, 1, 15, 15, 15);
    add(1,  80,  0, 1, 1, 15, 15,  0);
    add(1, 240,  0, 1, 1,  0, 15,  0);
    add(1, 400,  0, 1, 1, 15,  0,  0);
    add(1, 639,  0, 1, 1,  0,  0,  0);
    add(1, 640,  0, 0, 1,  0,  0,  0);
    add(1, 655,  0, 0, 1,  0,  0,  0);
    add(1, 656,  0, 0, 0,  0,  0,  0);
    add(1, 751,  0, 0, 0,  0,  0,  0);
    add(1, 752,  0, 0, 1,  0,  0,  0);
    add(0,   5,  3, 1, 1, 10,  5,  3);
    add(0, 700,  3, 0, 0,  0,  0,  0);
    add(3, 200, 17, 1, 1, 12,  1,  3);
    add(2,   0,  0, 1, 1, 10,  5,  3);
    add(2,  32,  0, 1, 1,  0,  0,  0);
    add(2,  32, 32, 1, 1, 10,  5,  3);
    add(2,  31, 63, 1, 1,  0,  0,  0);

    // Reset with pix_en high: reset must win.
    pe_a = 1'b1;
    pe_b = 1'b1;
    tick(); tick(); tick();
    check("a_rst_hs", int'(vid_a.h_sync), 1);
    check("a_rst_vs", int'(vid_a.v_sync), 1);
    check("a_rst_de", int'(vid_a.DE), 0);
    check("a_rst_xy", int'({vid_a.pixel_x, vid_a.pixel_y}), 0);
    check("a_rst_rgb", int'({vid_a.r_port, vid_a.g_port, vid_a.b_port}), 0);
    check("a_rst_fs", int'(vid_a.frame_start), 0);
    check("b_rst_hs", int'(vid_b.h_sync), 0);
    check("b_rst_vs", int'(vid_b.v_sync), 0);

    cur_mode = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].mode != cur_mode) begin
        restart_a(2'(vecs[i].mode));
        cur_mode = vecs[i].mode;
      end
      seek_a(vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_de", i), int'(vid_a.DE), vecs[i].de);
      check($sformatf("v%0d_hs", i), int'(vid_a.h_sync), vecs[i].hs);
      check($sformatf("v%0d_vs", i), int'(vid_a.v_sync), 1);
      check($sformatf("v%0d_r", i), int'(vid_a.r_port), vecs[i].r);
      check($sformatf("v%0d_g", i), int'(vid_a.g_port), vecs[i].g);
      check($sformatf("v%0d_b", i), int'(vid_a.b_port), vecs[i].b);
    end
    rst_a = 1'b0;
    pe_a  = 1'b0;

    // Whole frame on the small raster, solid mode.
    mode_b = 2'd0;
    rst_b  = 1'b1;
    fs_b   = 0;
    tick_b();
    check("b_fs_first", int'(vid_b.frame_start), 1);
    check("b_origin", int'({vid_b.pixel_x, vid_b.pixel_y}), 0);
    clks = 1;
    hs_n = int'(vid_b.h_sync);
    vs_n = int'(vid_b.v_sync);
    de_n = int'(vid_b.DE);
    while (clks < 2000) begin
      tick_b();
      if (vid_b.frame_start) break;
      hs_n += int'(vid_b.h_sync);
      vs_n += int'(vid_b.v_sync);
      de_n += int'(vid_b.DE);
      clks++;
    end
    check("b_frame_period", clks, 432);
    check("b_hs_clks", hs_n, 72);
    check("b_vs_clks", vs_n, 48);
    check("b_de_clks", de_n, 192);

    // Mid-frame mode change waits for the next frame start.
    seek_b(5, 3);
    mode_b = 2'd1;
    bad = 0;
    clks = 0;
    while (!vid_b.frame_start && clks < 1000) begin
      tick_b();
      clks++;
      if (!vid_b.frame_start && vid_b.DE &&
          {vid_b.r_port, vid_b.g_port, vid_b.b_port} != 12'hA53) bad++;
    end
    check("b_solid_until_fs", bad, 0);
    check("b_fs_after_switch", int'(vid_b.frame_start), 1);
    check("b_bar0_rgb", int'({vid_b.r_port, vid_b.g_port, vid_b.b_port}), 'hFFF);
    tick_b(); tick_b();
    check("b_bar1_rgb", int'({vid_b.r_port, vid_b.g_port, vid_b.b_port}), 'hFF0);
    tick_b(); tick_b();
    check("b_bar2_rgb", int'({vid_b.r_port, vid_b.g_port, vid_b.b_port}), 'h0FF);

    // Pixel enable 1-in-4: outputs hold between strobes, frame_start stays a single clk.
    hold_bad = 0;
    clks = 0;
    for (int c = 0; c < 8000; c++) begin
      pe_b = (c % 4 == 0);
      pe_used = pe_b;
      snap = {vid_b.pixel_x, vid_b.pixel_y, vid_b.DE, vid_b.h_sync, vid_b.v_sync,
              vid_b.r_port, vid_b.g_port, vid_b.b_port};
      tick_b();
      if (!pe_used && snap != {vid_b.pixel_x, vid_b.pixel_y, vid_b.DE, vid_b.h_sync,
                               vid_b.v_sync, vid_b.r_port, vid_b.g_port, vid_b.b_port})
        hold_bad++;
      if (clks > 0) clks++;
      if (vid_b.frame_start) begin
        if (clks > 0) break;
        clks = 1;
      end
    end
    check("b_gated_period", clks - 1, 1728);
    check("b_hold_violations", hold_bad, 0);
    pe_b = 1'b1;

    // Five frames of scrolling gradient, then a mid-frame reset.
    mode_b = 2'd3;
    for (int f = 0; f < 5; f++) wait_fs_b($sformatf("b_grad_fs%0d", f), 500, clks);
    seek_b(12, 0);
    check("b_grad_r", int'(vid_b.r_port), ((12 + fs_b) % 32) >> 4);
    check("b_grad_g", int'(vid_b.g_port), 0);
    check("b_grad_b", int'(vid_b.b_port), 3);
    seek_b(10, 5);
    rst_b = 1'b0;
    tick_b();
    check("b_mrst_de", int'(vid_b.DE), 0);
    check("b_mrst_sync", int'({vid_b.h_sync, vid_b.v_sync}), 0);
    check("b_mrst_xy", int'({vid_b.pixel_x, vid_b.pixel_y}), 0);
    check("b_mrst_rgb", int'({vid_b.r_port, vid_b.g_port, vid_b.b_port}), 0);
    check("b_mrst_fs", int'(vid_b.frame_start), 0);
    rst_b = 1'b1;
    fs_b  = 0;
    tick_b();
    check("b_rel_fs", int'(vid_b.frame_start), 1);
    check("b_rel_xy", int'({vid_b.pixel_x, vid_b.pixel_y}), 0);
    check("b_rel_r00", int'(vid_b.r_port), 0);
    check("b_rel_b00", int'(vid_b.b_port), 3);
    seek_b(12, 0);
    check("b_rel_r12", int'(vid_b.r_port), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_engine.md
VGA_PATTERN_ENGINE -- requirements
Module: vga_pattern_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE 640 visible pixels; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch.
REQ-002 Parameters SHALL also be: V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; COLOR_W 4 bits per channel; SYNC_POL 0 (0 = active-low sync); CHECK_LOG2 5 (checker square = 2^CHECK_LOG2 px).
REQ-003 Derived: H_TOTAL = sum of H params (800), V_TOTAL = sum of V params (525), X_W = clog2(H_TOTAL), Y_W = clog2(V_TOTAL); H_ACTIVE SHALL be a multiple of 8.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 pix_en  in  1  pixel-rate enable (e.g. 1-in-4 of 100 MHz); state advances only when high.
REQ-007 mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 scrolling gradient.
REQ-008 r_sw, g_sw, b_sw  in  COLOR_W each  user colour.
REQ-009 h_sync, v_sync  out  1 each  sync, polarity per SYNC_POL.
REQ-010 DE  out  1  display enable, high in visible area.
REQ-011 pixel_x  out  X_W; pixel_y  out  Y_W  coordinates of the pixel currently on r/g/b_port.
REQ-012 r_port, g_port, b_port  out  COLOR_W each  pixel colour.
REQ-013 frame_start  out  1  one-clk pulse marking output of pixel (0,0).

Function
REQ-014 h_cnt SHALL count 0..H_TOTAL-1 on pix_en, wrap to 0 and increment v_cnt; v_cnt SHALL wrap V_TOTAL-1 -> 0.
REQ-015 pix_en low SHALL hold every register, including outputs; frame_start SHALL not repeat while held.
REQ-016 Raw hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw vsync for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; output = raw when SYNC_POL=1, else inverted.
REQ-017 Raw DE = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-018 All outputs SHALL be registered, updated on the same pix_en cycle, latency exactly one pix_en from counter value; syncs, DE, pixel_x/y, RGB mutually aligned.
REQ-019 RGB SHALL be all-zero whenever DE output is 0, in every mode.
REQ-020 mode SHALL be sampled into mode_q only at frame start (h_cnt=0, v_cnt=0, pix_en=1); mid-frame changes take effect next frame.
REQ-021 frame_cnt (8 bit) SHALL increment at each frame start, wrapping 255 -> 0.
REQ-022 Mode 0: RGB = r_sw, g_sw, b_sw.
REQ-023 Mode 1: bar k = floor(x / (H_ACTIVE/8)); R full-scale for k in {0,1,4,5}, G for k in {0,1,2,3}, B for k in {0,2,4,6}, else 0 (white, yellow, cyan, green, magenta, red, blue, black).
REQ-024 Mode 2: if bit0 of ((x >> CHECK_LOG2) xor (y >> CHECK_LOG2)) = 0 then switch colour, else 0.
REQ-025 Mode 3: R = bits [COLOR_W+3:4] of (x + frame_cnt) mod 2^X_W; G = bits [COLOR_W+3:4] of y; B = b_sw.
REQ-026 frame_start SHALL be high for exactly one clk, on the clk where outputs present pixel (0,0).
REQ-027 Sync, DE and RGB SHALL be combinational-glitch-free (driven directly from flops).

Reset
REQ-028 While reset=0 at a clk edge: h_cnt, v_cnt, frame_cnt, mode_q = 0; DE, RGB, pixel_x/y, frame_start = 0; h_sync/v_sync at inactive level.
REQ-029 Reset SHALL dominate pix_en; reset mid-frame restarts timing at (0,0), first frame_start on first pix_en after release.

Verification
REQ-030 Defaults, pix_en=1: h_sync low for 96 clks starting at pixel_x=656; period 800 clks; DE high for pixel_x 0..639 only.
REQ-031 v_sync low exactly while pixel_y in {490,491}; frame_start period 420000 pix_en cycles; pix_en 1-in-4 -> 1680000 clks.
REQ-032 Mode 1: x=0 -> F,F,F; x=80 -> F,F,0; x=400 -> F,0,0; x=639 -> 0,0,0; x=640 -> DE=0, 0,0,0.
REQ-033 Mode 2, sw=A,5,3: (0,0) -> A,5,3; (32,0) -> 0,0,0; (32,32) -> A,5,3; (31,63) -> 0,0,0.
REQ-034 Switch mode 0->1 at pixel (100,200): output stays solid until next frame_start, then bars from pixel (0,0).
REQ-035 Assert reset at h_cnt=300, v_cnt=10 in mode 3 after 5 frames: outputs reset values; after release frame_cnt=0, next frame_start, pixel (0,0) R = 0.
